// File: rtl/proc_pkg.sv
// Shared definitions for the 8-bit processor datapath: opcodes, sequencer
// states, instruction field positions and the widths regfile_8x8 must match.
package proc_pkg;

  localparam int IW = 16;
  localparam int DW = 8;
  localparam int AW = 3;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_AND = 4'h3,
    OP_OR  = 4'h4,
    OP_XOR = 4'h5,
    OP_SHL = 4'h6,
    OP_SHR = 4'h7,
    OP_LDI = 4'h8,
    OP_MOV = 4'h9,
    OP_CMP = 4'hA
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_EX   = 2'd2,
    S_WB   = 2'd3
  } state_t;

  function automatic logic is_legal(input logic [3:0] op);
    return (op <= 4'hA);
  endfunction

endpackage

// File: rtl/alu_8bit.sv
// Combinational ALU for the sequencer's EX stage: result, carry/borrow, zero,
// plus per-opcode decode of whether flags update and whether rd is written.
module alu_8bit
  import proc_pkg::*;
(
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] imm8,
  output logic [DW-1:0] res,
  output logic          c,
  output logic          z,
  output logic          upd_flags,
  output logic          wr_en
);

  logic [DW:0] sum;
  logic [DW:0] diff;

  // Ninth bit of the widened subtraction is the unsigned borrow (a < b).
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    res       = '0;
    c         = 1'b0;
    upd_flags = 1'b0;
    wr_en     = 1'b0;
    case (op)
      OP_ADD: begin res = sum[DW-1:0];  c = sum[DW];  upd_flags = 1'b1; wr_en = 1'b1; end
      OP_SUB: begin res = diff[DW-1:0]; c = diff[DW]; upd_flags = 1'b1; wr_en = 1'b1; end
      OP_AND: begin res = a & b;        upd_flags = 1'b1; wr_en = 1'b1; end
      OP_OR:  begin res = a | b;        upd_flags = 1'b1; wr_en = 1'b1; end
      OP_XOR: begin res = a ^ b;        upd_flags = 1'b1; wr_en = 1'b1; end
      OP_SHL: begin res = a << b[2:0];  upd_flags = 1'b1; wr_en = 1'b1; end
      OP_SHR: begin res = a >> b[2:0];  upd_flags = 1'b1; wr_en = 1'b1; end
      OP_LDI: begin res = imm8;         wr_en = 1'b1; end
      OP_MOV: begin res = a;            wr_en = 1'b1; end
      OP_CMP: begin res = diff[DW-1:0]; c = diff[DW]; upd_flags = 1'b1; end
      default: ;
    endcase
  end

  assign z = (res == '0);

endmodule

// File: rtl/regfile_8x8.sv
// Eight 8-bit registers: two combinational read ports, one synchronous write.
module regfile_8x8
  import proc_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  output logic [DW-1:0] rd_a,
  output logic [DW-1:0] rd_b,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**AW; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[wa] <= wd;
    end
  end

  assign rd_a = mem_q[ra];
  assign rd_b = mem_q[rb];

endmodule

// File: rtl/exec_seq.sv
// Four-state instruction sequencer (IDLE/RD/EX/WB) driving regfile_8x8.
// Handshake: an instruction transfers on a rising edge where in_valid && in_ready.
module exec_seq
  import proc_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [IW-1:0] in_instr,
  output logic          in_ready,
  output logic [AW-1:0] ra,
  output logic [AW-1:0] rb,
  input  logic [DW-1:0] rd_a,
  input  logic [DW-1:0] rd_b,
  output logic          we,
  output logic [AW-1:0] wa,
  output logic [DW-1:0] wd,
  output logic          flag_z,
  output logic          flag_c,
  output logic          done,
  output logic          err
);

  state_t        state_q, state_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [DW-1:0] op_a_q, op_a_d;
  logic [DW-1:0] op_b_q, op_b_d;
  logic [DW-1:0] res_q, res_d;
  logic          flag_z_q, flag_z_d;
  logic          flag_c_q, flag_c_d;

  logic [3:0]    opcode;
  logic [DW-1:0] alu_res;
  logic          alu_c, alu_z, alu_upd, alu_wr;

  assign opcode = instr_q[OP_MSB:OP_LSB];

  alu_8bit u_alu (
    .op        (opcode),
    .a         (op_a_q),
    .b         (op_b_q),
    .imm8      (instr_q[IMM_MSB:IMM_LSB]),
    .res       (alu_res),
    .c         (alu_c),
    .z         (alu_z),
    .upd_flags (alu_upd),
    .wr_en     (alu_wr)
  );

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    res_d    = res_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          instr_d = in_instr;
          state_d = S_RD;
        end
      end
      S_RD: begin
        op_a_d  = rd_a;
        op_b_d  = rd_b;
        state_d = S_EX;
      end
      S_EX: begin
        res_d = alu_res;
        if (alu_upd) begin
          flag_z_d = alu_z;
          flag_c_d = alu_c;
        end
        state_d = S_WB;
      end
      S_WB: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      res_q    <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      res_q    <= res_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

  // Read addresses come straight from the latched word, so they hold through WB.
  assign in_ready = (state_q == S_IDLE);
  assign ra       = instr_q[RS1_MSB:RS1_LSB];
  assign rb       = instr_q[RS2_MSB:RS2_LSB];
  assign we       = (state_q == S_WB) && alu_wr;
  assign wa       = instr_q[RD_MSB:RD_LSB];
  assign wd       = res_q;
  assign flag_z   = flag_z_q;
  assign flag_c   = flag_c_q;
  assign done     = (state_q == S_WB);
  assign err      = (state_q == S_WB) && !is_legal(opcode);

endmodule
